// File: rtl/store_unit.sv
// store_unit: memory-stage store engine. Accepts a byte-addressed store from the
// ALU, issues one or two word-aligned bus writes with byte enables (splitting
// accesses that straddle a word boundary) and reports completion or error.
module store_unit #(
  parameter int TIMEOUT = 15  // max wait cycles per beat for mem_ack; 0 = wait forever
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        st_valid,
  output logic        st_ready,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_data,
  input  logic [1:0]  st_size,
  output logic        st_done,
  output logic        st_err,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ack
);

  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, RESP} state_t;

  state_t      state;
  logic [3:0]  be1;        // upper-word byte enables, zero when no second beat
  logic [31:0] wd1;        // upper-word lane-positioned data
  logic [15:0] cnt;        // cycles spent waiting in the current beat

  logic [7:0]  base_mask;
  logic [7:0]  mask8;
  logic [63:0] data64;
  logic        timeout_hit;

  // Lane placement of the incoming request across a two-word window.
  always_comb begin
    base_mask = 8'h00;
    case (st_size)
      2'b00:   base_mask = 8'h01;
      2'b01:   base_mask = 8'h03;
      2'b10:   base_mask = 8'h0F;
      default: base_mask = 8'h00;
    endcase
    mask8  = base_mask << st_addr[1:0];
    data64 = {32'h0000_0000, st_data} << {st_addr[1:0], 3'b000};
  end

  // Expiry fires on the edge that ends the TIMEOUT-th waiting cycle of a beat.
  assign timeout_hit = (TIMEOUT > 0) && (cnt == 16'(TIMEOUT - 1));

  // Store sequencer: all outputs are registered and updated with the state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      st_ready  <= 1'b1;
      st_done   <= 1'b0;
      st_err    <= 1'b0;
      mem_req   <= 1'b0;
      mem_addr  <= 32'h0000_0000;
      mem_wdata <= 32'h0000_0000;
      mem_be    <= 4'h0;
      be1       <= 4'h0;
      wd1       <= 32'h0000_0000;
      cnt       <= 16'h0000;
    end else begin
      case (state)
        IDLE: begin
          if (st_valid) begin
            st_ready <= 1'b0;
            if (st_size == 2'b11) begin
              state   <= RESP;
              st_done <= 1'b1;
              st_err  <= 1'b1;
            end else begin
              state     <= BEAT0;
              mem_req   <= 1'b1;
              mem_addr  <= {st_addr[31:2], 2'b00};
              mem_be    <= mask8[3:0];
              mem_wdata <= data64[31:0];
              be1       <= mask8[7:4];
              wd1       <= data64[63:32];
              cnt       <= 16'h0000;
            end
          end else begin
            st_ready <= 1'b1;
          end
        end
        BEAT0: begin
          if (mem_ack) begin
            if (be1 != 4'h0) begin
              state     <= BEAT1;
              mem_addr  <= mem_addr + 32'd4;
              mem_be    <= be1;
              mem_wdata <= wd1;
              cnt       <= 16'h0000;
            end else begin
              state   <= RESP;
              mem_req <= 1'b0;
              st_done <= 1'b1;
              st_err  <= 1'b0;
            end
          end else if (timeout_hit) begin
            // A failed first beat never proceeds to the second one.
            state   <= RESP;
            mem_req <= 1'b0;
            st_done <= 1'b1;
            st_err  <= 1'b1;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        BEAT1: begin
          if (mem_ack) begin
            state   <= RESP;
            mem_req <= 1'b0;
            st_done <= 1'b1;
            st_err  <= 1'b0;
          end else if (timeout_hit) begin
            state   <= RESP;
            mem_req <= 1'b0;
            st_done <= 1'b1;
            st_err  <= 1'b1;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        RESP: begin
          state    <= IDLE;
          st_done  <= 1'b0;
          st_err   <= 1'b0;
          st_ready <= 1'b1;
        end
        default: begin
          state    <= IDLE;
          st_ready <= 1'b1;
          st_done  <= 1'b0;
          st_err   <= 1'b0;
          mem_req  <= 1'b0;
        end
      endcase
    end
  end

endmodule
